sort_sched: RTL and testbench
=============================

Name: sort_sched

Overview:
- Batch scheduler that feeds the odd/even sort stage (`sort` module) from two independent requesters.
- Accepts a programmed number of words, arbitrating round-robin between requester 0 and requester 1.
- Drives the sorter's enable/num inputs, one registered word per cycle.
- Tallies odd/even counts and pulses done when the batch completes.
- Sits between upstream producers and the sort stage; sorter outputs are not routed through this block.

Parameters:
- WIDTH, 32, data word width; must match the sort stage WIDTH.
- CNTW, 8, width of batch_len and of the odd/even tally counters.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle batch start request
- batch_len  input  CNTW  number of words in the batch; sampled on accepted start
- req0_valid  input  1  requester 0 has a word
- req0_num  input  WIDTH  requester 0 data
- req0_ready  output  1  requester 0 word accepted this cycle (combinational)
- req1_valid  input  1  requester 1 has a word
- req1_num  input  WIDTH  requester 1 data
- req1_ready  output  1  requester 1 word accepted this cycle (combinational)
- sort_enable  output  1  to sorter enable; registered
- sort_num  output  WIDTH  to sorter num; registered
- odd_cnt  output  CNTW  odd words dispatched in current/last batch
- even_cnt  output  CNTW  even words dispatched in current/last batch
- busy  output  1  high in RUN
- done  output  1  one-cycle completion pulse
- last_grant  output  1  index of the most recently granted requester

Behaviour:
- Reset (asynchronous, active-low) values:
  - State → IDLE.
  - sort_enable, sort_num, odd_cnt, even_cnt, busy, done, last_grant → 0.
  - Remaining count → 0; round-robin pointer → requester 0.
  - Reset mid-batch aborts the batch; no partial done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req*_ready = 0.
  - On start=1: latch batch_len into the remaining counter and clear odd_cnt/even_cnt.
  - If batch_len != 0, go to RUN. If batch_len == 0, go to DONE.
- RUN:
  - busy = 1. At most one grant per cycle.
  - Grant goes to the pointer-preferred requester if its valid=1, else to the other requester if its valid=1.
  - reqN_ready = 1 only for the granted requester. The transfer occurs when valid & ready.
  - On a transfer:
    - Pointer moves to the non-granted requester; last_grant = granted index.
    - Remaining count decrements.
    - Next cycle: sort_enable = 1 and sort_num = the accepted word.
    - Next cycle: odd_cnt increments if num[0] = 1, else even_cnt increments.
  - Latency: accept at cycle T → sort_enable / sort_num / counter update visible at T+1. The sorter register then updates at T+2.
  - If the transfer takes the remaining count to 0, go to DONE at T+1.
- DONE:
  - done = 1 for exactly one cycle; busy = 0; ready outputs = 0.
  - The final word's sort_enable is high in this same cycle.
  - Always returns to IDLE next cycle.
- start while in RUN or DONE is ignored (not queued).
- sort_enable = 0 in every cycle with no transfer on the previous cycle. sort_num holds its last value when sort_enable = 0.
- Requesters may drop valid at any time. No valid → no grant, no pointer change.
- Counters never wrap within a batch, since odd_cnt + even_cnt ≤ batch_len ≤ 2^CNTW − 1.
- odd_cnt and even_cnt hold after DONE until the next accepted start.

Test Plan:
- Reset behaviour: assert reset low mid-RUN after 3 of 5 words → all outputs 0, state IDLE; no done pulse after release.
- Single requester: start with batch_len=4; req0 streams 1, 2, 3, 4 continuously (req1 idle).
  - sort_enable high for 4 consecutive cycles, each 1 cycle after its accept.
  - odd_cnt=2, even_cnt=2; done pulses the cycle after the 4th accept.
- Round-robin fairness: both valid continuously, req0 = 0x10 and req1 = 0x21 constant, batch_len=6.
  - Grants alternate 0, 1, 0, 1, 0, 1.
  - sort_num sequence 0x10, 0x21, …; even_cnt=3, odd_cnt=3; last_grant=1 at the end.
- Zero-length batch: start with batch_len=0 → done high on the cycle after start; no ready or sort_enable ever asserted; counts 0.
- Gaps and ignored start: batch_len=3 with req1 valid only every other cycle, plus a start pulse mid-RUN.
  - Exactly 3 transfers occur; the extra start is ignored; done fires once.
  - A new start with batch_len=1 afterwards clears the counts and runs correctly.
- Full-width data: WIDTH=32 with words 0xFFFFFFFF and 0x80000000.
  - Parity is taken from bit 0 only: odd_cnt=1, even_cnt=1.
  - sort_num matches the words bit-exact.

Source files
------------

// File: rtl/sort_sched.sv
// Batch scheduler for the odd/even sort stage.
// It arbitrates round-robin between two requesters and drives one registered word per cycle.
module sort_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNTW-1:0]  batch_len,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_num,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_num,
    output logic             req1_ready,
    output logic             sort_enable,
    output logic [WIDTH-1:0] sort_num,
    output logic [CNTW-1:0]  odd_cnt,
    output logic [CNTW-1:0]  even_cnt,
    output logic             busy,
    output logic             done,
    output logic             last_grant
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNTW-1:0]  remaining;
    logic             ptr;
    logic             gnt_any;
    logic             gnt_idx;
    logic [WIDTH-1:0] gnt_word;

    // Preferred requester wins if valid, otherwise the other one gets the slot.
    always_comb begin
        gnt_any  = (state == S_RUN) && (req0_valid || req1_valid);
        gnt_idx  = ptr ? req1_valid : !req0_valid;
        gnt_word = gnt_idx ? req1_num : req0_num;
    end

    assign req0_ready = gnt_any && !gnt_idx;
    assign req1_ready = gnt_any && gnt_idx;
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            remaining   <= '0;
            ptr         <= 1'b0;
            last_grant  <= 1'b0;
            sort_enable <= 1'b0;
            sort_num    <= '0;
            odd_cnt     <= '0;
            even_cnt    <= '0;
        end else begin
            sort_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= batch_len;
                        odd_cnt   <= '0;
                        even_cnt  <= '0;
                        state     <= (batch_len != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (gnt_any) begin
                        ptr         <= !gnt_idx;
                        last_grant  <= gnt_idx;
                        remaining   <= remaining - 1'b1;
                        sort_enable <= 1'b1;
                        sort_num    <= gnt_word;
                        if (gnt_word[0]) begin
                            odd_cnt <= odd_cnt + 1'b1;
                        end else begin
                            even_cnt <= even_cnt + 1'b1;
                        end
                        if (remaining == CNTW'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_sched.sv
// Directed self-checking bench for sort_sched.
// Inputs change 1ns after the rising edge and outputs are checked there too.
module tb_sort_sched;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNTW  = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNTW-1:0]  batch_len;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_num;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_num;
    logic             req1_ready;
    logic             sort_enable;
    logic [WIDTH-1:0] sort_num;
    logic [CNTW-1:0]  odd_cnt;
    logic [CNTW-1:0]  even_cnt;
    logic             busy;
    logic             done;
    logic             last_grant;

    int errors = 0;
    int checks = 0;

    sort_sched #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .batch_len  (batch_len),
        .req0_valid (req0_valid),
        .req0_num   (req0_num),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_num   (req1_num),
        .req1_ready (req1_ready),
        .sort_enable(sort_enable),
        .sort_num   (sort_num),
        .odd_cnt    (odd_cnt),
        .even_cnt   (even_cnt),
        .busy       (busy),
        .done       (done),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".sort_enable"}, 32'(sort_enable), 32'd0);
        chk({tag, ".sort_num"}, sort_num, 32'd0);
        chk({tag, ".odd_cnt"}, 32'(odd_cnt), 32'd0);
        chk({tag, ".even_cnt"}, 32'(even_cnt), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".last_grant"}, 32'(last_grant), 32'd0);
        chk({tag, ".req0_ready"}, 32'(req0_ready), 32'd0);
        chk({tag, ".req1_ready"}, 32'(req1_ready), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        batch_len  = '0;
        req0_valid = 1'b0;
        req0_num   = '0;
        req1_valid = 1'b0;
        req1_num   = '0;
        tick();
        chk_all_zero("por");
        tick();
        reset = 1'b1;
        tick();

        // ---- reset mid-RUN after 3 of 5 words ----
        start = 1'b1; batch_len = 8'd5;
        tick();
        start = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_num = 32'(5 + i);
            #1;
            chk("rst.ready0", 32'(req0_ready), 32'd1);
            tick();
            chk("rst.sort_num", sort_num, 32'(5 + i));
        end
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rst.async");
        tick();
        chk_all_zero("rst.held");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst.no_done", 32'(done), 32'd0);
            chk("rst.idle_busy", 32'(busy), 32'd0);
            chk("rst.idle_ready0", 32'(req0_ready), 32'd0);
        end
        req0_valid = 1'b0;

        // ---- round-robin, both valid, batch 6 (pointer reset to 0) ----
        start = 1'b1; batch_len = 8'd6;
        tick();
        start = 1'b0;
        req0_valid = 1'b1; req0_num = 32'h10;
        req1_valid = 1'b1; req1_num = 32'h21;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr.ready0", 32'(req0_ready), 32'(k % 2 == 0));
            chk("rr.ready1", 32'(req1_ready), 32'(k % 2 == 1));
            tick();
            chk("rr.sort_enable", 32'(sort_enable), 32'd1);
            chk("rr.sort_num", sort_num, (k % 2 == 0) ? 32'h10 : 32'h21);
            chk("rr.last_grant", 32'(last_grant), 32'(k % 2));
        end
        chk("rr.done", 32'(done), 32'd1);
        chk("rr.even", 32'(even_cnt), 32'd3);
        chk("rr.odd", 32'(odd_cnt), 32'd3);
        chk("rr.done_ready0", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("rr.done_pulse", 32'(done), 32'd0);
        chk("rr.en_off", 32'(sort_enable), 32'd0);
        chk("rr.num_hold", sort_num, 32'h21);

        // ---- zero-length batch, requesters valid throughout ----
        req0_valid = 1'b1; req1_valid = 1'b1;
        start = 1'b1; batch_len = 8'd0;
        #1;
        chk("zero.idle_ready0", 32'(req0_ready), 32'd0);
        tick();
        start = 1'b0;
        #1;
        chk("zero.done", 32'(done), 32'd1);
        chk("zero.busy", 32'(busy), 32'd0);
        chk("zero.sort_enable", 32'(sort_enable), 32'd0);
        chk("zero.ready0", 32'(req0_ready), 32'd0);
        chk("zero.ready1", 32'(req1_ready), 32'd0);
        chk("zero.odd", 32'(odd_cnt), 32'd0);
        chk("zero.even", 32'(even_cnt), 32'd0);
        tick();
        chk("zero.done_pulse", 32'(done), 32'd0);
        chk("zero.en_after", 32'(sort_enable), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // ---- gaps on req1 plus an ignored start mid-RUN ----
        start = 1'b1; batch_len = 8'd3;
        tick();
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            req1_valid = (c % 2 == 0);
            req1_num   = 32'h30 + 32'(c / 2);
            start      = (c == 1);
            batch_len  = (c == 1) ? 8'd9 : 8'd3;
            #1;
            chk("gap.ready1", 32'(req1_ready), 32'(c % 2 == 0 && c <= 4));
            tick();
            chk("gap.sort_enable", 32'(sort_enable), 32'(c % 2 == 0 && c <= 4));
            chk("gap.done", 32'(done), 32'(c == 4));
            if (c == 2) chk("gap.sort_num", sort_num, 32'h31);
        end
        start = 1'b0; req1_valid = 1'b0;
        chk("gap.busy_end", 32'(busy), 32'd0);
        chk("gap.even", 32'(even_cnt), 32'd2);
        chk("gap.odd", 32'(odd_cnt), 32'd1);

        // ---- new batch of 1 clears counts ----
        start = 1'b1; batch_len = 8'd1;
        tick();
        start = 1'b0;
        chk("one.busy", 32'(busy), 32'd1);
        chk("one.odd_clr", 32'(odd_cnt), 32'd0);
        chk("one.even_clr", 32'(even_cnt), 32'd0);
        req0_valid = 1'b1; req0_num = 32'd7;
        tick();
        req0_valid = 1'b0;
        chk("one.done", 32'(done), 32'd1);
        chk("one.sort_num", sort_num, 32'd7);
        chk("one.odd", 32'(odd_cnt), 32'd1);
        chk("one.even", 32'(even_cnt), 32'd0);
        tick();

        // ---- full-width words; pointer now prefers req1 ----
        start = 1'b1; batch_len = 8'd2;
        tick();
        start = 1'b0;
        req0_valid = 1'b1; req0_num = 32'hFFFF_FFFF;
        req1_valid = 1'b1; req1_num = 32'h8000_0000;
        #1;
        chk("fw.ready1_first", 32'(req1_ready), 32'd1);
        tick();
        chk("fw.word0", sort_num, 32'h8000_0000);
        tick();
        chk("fw.word1", sort_num, 32'hFFFF_FFFF);
        chk("fw.done", 32'(done), 32'd1);
        chk("fw.odd", 32'(odd_cnt), 32'd1);
        chk("fw.even", 32'(even_cnt), 32'd1);
        chk("fw.last_grant", 32'(last_grant), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("fw.idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
